// File: rtl/block_stats_buffer.sv
// Buffers one pixel block and computes its mean and variance.
// Then replays the block in order, together with the block stats.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid, in_data  pixel input stream
//   in_ready           high while accepting pixels
//   blocks_per_frame   blocks per frame, latched at each block start
//   stats_ready        pulse on the first replay cycle
//   mean_of_block      block mean
//   variance_of_block  block variance
//   data_out           replayed pixel
//   data_out_valid     data_out is valid
//   frame_last         high during replay of a frame's last block
module block_stats_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  input  logic [31:0]             blocks_per_frame,
  output logic                    stats_ready,
  output logic [2*DATA_WIDTH-1:0] mean_of_block,
  output logic [2*DATA_WIDTH-1:0] variance_of_block,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  output logic                    frame_last
);

  localparam int LG = $clog2(TOTAL_SAMPLES);
  localparam int SW = DATA_WIDTH + LG;
  localparam int QW = 2 * DATA_WIDTH + LG;
  localparam int OW = 2 * DATA_WIDTH;
  localparam logic [LG-1:0] LAST = LG'(TOTAL_SAMPLES - 1);

  typedef enum logic [1:0] {
    ACCUM,
    FINALIZE,
    REPLAY
  } state_t;

  state_t                state;
  logic [LG-1:0]         wr_cnt;
  logic [LG-1:0]         rd_cnt;
  logic [LG-1:0]         rd_nxt;
  logic [SW-1:0]         sum;
  logic [QW-1:0]         sumsq;
  logic [31:0]           blk_cnt;
  logic [31:0]           bpf_q;
  logic [31:0]           bpf_eff;
  logic                  accept;
  logic                  last_blk;
  logic [DATA_WIDTH-1:0] mean_w;
  logic [OW-1:0]         msq_w;
  logic [OW-1:0]         avgsq_w;
  logic [OW-1:0]         sq_w;
  logic [DATA_WIDTH-1:0] mem [TOTAL_SAMPLES];

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign rd_nxt   = rd_cnt + LG'(1);
  assign sq_w     = OW'(in_data) * OW'(in_data);
  assign mean_w   = DATA_WIDTH'(sum >> LG);
  assign msq_w    = OW'(mean_w) * OW'(mean_w);
  assign avgsq_w  = OW'(sumsq >> LG);
  // a frame of zero blocks is treated as one block per frame
  assign bpf_eff  = (blocks_per_frame == 32'd0) ?
                    32'd1 : blocks_per_frame;
  assign last_blk = (blk_cnt >= bpf_q - 32'd1);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ACCUM;
      wr_cnt            <= '0;
      rd_cnt            <= '0;
      sum               <= '0;
      sumsq             <= '0;
      blk_cnt           <= '0;
      bpf_q             <= 32'd1;
      stats_ready       <= 1'b0;
      data_out_valid    <= 1'b0;
      frame_last        <= 1'b0;
      data_out          <= '0;
      mean_of_block     <= '0;
      variance_of_block <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            sum    <= sum + SW'(in_data);
            sumsq  <= sumsq + QW'(sq_w);
            wr_cnt <= wr_cnt + LG'(1);
            if (wr_cnt == '0) bpf_q <= bpf_eff;
            if (wr_cnt == LAST) state <= FINALIZE;
          end
        end
        FINALIZE: begin
          mean_of_block     <= OW'(mean_w);
          variance_of_block <= avgsq_w - msq_w;
          data_out          <= mem[0];
          data_out_valid    <= 1'b1;
          stats_ready       <= 1'b1;
          frame_last        <= last_blk;
          blk_cnt           <= last_blk ? 32'd0 : blk_cnt + 32'd1;
          sum               <= '0;
          sumsq             <= '0;
          wr_cnt            <= '0;
          rd_cnt            <= '0;
          state             <= REPLAY;
        end
        REPLAY: begin
          stats_ready <= 1'b0;
          if (rd_cnt == LAST) begin
            data_out_valid <= 1'b0;
            frame_last     <= 1'b0;
            state          <= ACCUM;
          end else begin
            rd_cnt   <= rd_nxt;
            data_out <= mem[rd_nxt];
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/block_stats_buffer.md
# block_stats_buffer

Upstream stage of the per-block Wiener filter. It accepts a raw pixel-channel stream one block at a time and stores the block in an internal buffer. In parallel it accumulates the block's sum and sum of squares, then produces the block mean and variance. It then replays the stored pixels in order, aligned with a one-cycle `stats_ready` pulse, so the downstream Wiener calculator's `data_in`, `mean_of_block`, `variance_of_block` and `stats_ready` inputs connect directly.

## Interface
- `DATA_WIDTH`, 8: pixel channel width.
- `TOTAL_SAMPLES`, 64: pixels per block; must be a power of 2, ≥ 4.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_data`  in  `DATA_WIDTH`  pixel channel value, raster order within block.
- `in_ready`  out  1  block accepts a pixel this cycle.
- `blocks_per_frame`  in  32  blocks per frame; sampled at each block start.
- `stats_ready`  out  1  one-cycle pulse on the first replay cycle.
- `mean_of_block`  out  `2*DATA_WIDTH`  floor(sum/N), zero-extended.
- `variance_of_block`  out  `2*DATA_WIDTH`  floor(sumsq/N) − mean².
- `data_out`  out  `DATA_WIDTH`  replayed pixel.
- `data_out_valid`  out  1  `data_out` is valid.
- `frame_last`  out  1  high for the entire replay of the last block of a frame.

## Operation
- States:
  - `ACCUM`: the reset state; `in_ready` = 1.
  - `FINALIZE`: one cycle.
  - `REPLAY`: exactly N cycles; `in_ready` = 0.
- `ACCUM`:
  - On each cycle with `in_valid && in_ready`, write `in_data` to `buf[wr_cnt]`, add it to `sum`, add its square to `sumsq`, and increment `wr_cnt`.
  - Acceptance of sample N−1 moves the FSM to `FINALIZE`.
  - `in_valid` = 0 simply stalls; no timeout.
- Accumulator widths:
  - `sum`: `DATA_WIDTH` + log2(N) bits.
  - `sumsq`: 2·`DATA_WIDTH` + log2(N) bits.
  - Neither can overflow.
- `FINALIZE` (registered results):
  - mean = `sum` >> log2(N).
  - variance = (`sumsq` >> log2(N)) − mean².
  - The result is always ≥ 0, and for 8-bit data it fits 16 bits. No divider is used, only shifts.
  - Also in this cycle: preload `data_out` ← `buf[0]`, and clear `sum`, `sumsq` and `wr_cnt`.
- `REPLAY`:
  - Cycle k (0…N−1) presents `buf[k]` on `data_out` with `data_out_valid` = 1.
  - `stats_ready` = 1 only at k = 0.
  - After k = N−1 the FSM returns to `ACCUM`.
- `mean_of_block` and `variance_of_block` update only at the end of `FINALIZE`. They hold through `REPLAY` and through the following `ACCUM` until the next `FINALIZE`.
- Frame tracking:
  - `blk_cnt` counts completed blocks.
  - `frame_last` = 1 during `REPLAY` when `blk_cnt` == `blocks_per_frame`−1.
  - `blk_cnt` wraps to 0 after that block and increments otherwise.
  - If `blocks_per_frame` == 0, the block treats it as 1, so `frame_last` is set for every block.
- Pixels presented while `in_ready` = 0 are not consumed; the source must hold them.

## Timing
- Reset values:
  - state = `ACCUM`; `wr_cnt`, `sum`, `sumsq`, `blk_cnt` = 0.
  - `in_ready` = 1 from the first cycle after reset release.
  - `stats_ready`, `data_out_valid`, `frame_last` = 0.
  - `data_out`, `mean_of_block`, `variance_of_block` = 0.
  - Buffer contents are don't-care.
- Latency: if sample N−1 is accepted at edge t, then `FINALIZE` is cycle t..t+1, and `stats_ready` plus `buf[0]` appear at cycle t+1..t+2. The last pixel leaves at cycle t+N.
- Throughput:
  - Minimum block period is 2N+1 cycles: N accept, 1 finalize, N replay.
  - This guarantees ≥ N+1 cycles between `stats_ready` pulses. The downstream stage needs N+1 cycles per block (N samples plus one return-to-idle cycle).
- All outputs are registered; there are no combinational input-to-output paths except `in_ready`, which is decoded from the state register only.
- Reset asserted mid-block or mid-replay: on the next edge all state clears, the partial block is discarded, and any replay stops immediately.
- `in_valid` held high in `FINALIZE`/`REPLAY`: no effect. The first accept after replay lands in `ACCUM` at `buf[0]`.

## Test plan
- N=64, all pixels 100, continuous `in_valid` -> `stats_ready` pulses 2 cycles after the 64th accept; mean = 100, variance = 0; `data_out` = 100 for 64 cycles.
- Ramp 0..63 -> mean = 31, variance = 1333 − 961 = 372; `data_out` replays 0..63 in order with `stats_ready` only with pixel 0.
- Alternating 0/255 -> sum = 8160, mean = 127, sumsq/64 floor = 32512, variance = 16383.
- Random `in_valid` gaps (≈50%) plus `in_valid` held high during replay -> the same stats and replay as gap-free input; `in_ready` = 0 for exactly N+1 cycles per block; no pixel lost or duplicated.
- `blocks_per_frame` = 3, 7 back-to-back blocks -> `frame_last` high during replay of blocks 2 and 5 only; mean/variance stay stable across each replay.
- Reset pulse after 30 accepts, then a full block of constant 7 -> no `stats_ready` for the partial block; the next block gives mean = 7, variance = 0.
